// File: rtl/pmp_csr_regs.sv
// PMP configuration/address CSR file (pmpcfg0..3, pmpaddr0..15) for RV32.
// Single-beat valid/ready request channel with a one-entry response buffer.
module pmp_csr_regs #(
  parameter int NUM_ENTRIES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     csr_req_valid,
  output logic                     csr_req_ready,
  input  logic                     csr_we,
  input  logic [11:0]              csr_addr,
  input  logic [31:0]              csr_wdata,
  output logic                     csr_rsp_valid,
  input  logic                     csr_rsp_ready,
  output logic [31:0]              csr_rdata,
  output logic                     csr_rsp_err,
  output logic [8*NUM_ENTRIES-1:0] pmpcfg_o,
  output logic [32*NUM_ENTRIES-1:0] pmpaddr_o
);

  // Handshake: a request transfers on an edge where csr_req_valid && csr_req_ready;
  // a response transfers where csr_rsp_valid && csr_rsp_ready. The response buffer
  // holds one entry, so a new request is taken only if that entry is empty or draining.
  logic accept;
  logic is_cfg;
  logic is_addr;
  logic [31:0] rd_val;
  logic rd_err;
  logic [NUM_ENTRIES-1:0] cfg_we;
  logic [NUM_ENTRIES-1:0] addr_we;
  logic [7:0]  cfg_q  [NUM_ENTRIES];
  logic [31:0] addr_q [NUM_ENTRIES];

  assign csr_req_ready = !csr_rsp_valid || csr_rsp_ready;
  assign accept        = csr_req_valid && csr_req_ready;
  assign is_cfg        = (csr_addr[11:2] == 10'h0E8);
  assign is_addr       = (csr_addr[11:4] == 8'h3B);

  for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_entry
    localparam logic [1:0] K = 2'(e / 4);
    localparam logic [3:0] I = 4'(e);
    logic [7:0] wbyte;
    logic       addr_locked;

    assign wbyte = csr_wdata[8*(e%4) +: 8];

    // A locked TOR entry also protects the address register below it.
    if (e < NUM_ENTRIES - 1) begin : g_tor
      assign addr_locked = cfg_q[e][7] ||
                           (cfg_q[e+1][7] && (cfg_q[e+1][4:3] == 2'b01));
    end else begin : g_last
      assign addr_locked = cfg_q[e][7];
    end

    // R=0,W=1 is a reserved combination: the byte keeps its old value.
    assign cfg_we[e]  = accept && csr_we && is_cfg && (csr_addr[1:0] == K) &&
                        !cfg_q[e][7] && (wbyte[1:0] != 2'b10);
    assign addr_we[e] = accept && csr_we && is_addr && (csr_addr[3:0] == I) &&
                        !addr_locked;

    assign pmpcfg_o[8*e +: 8]   = cfg_q[e];
    assign pmpaddr_o[32*e +: 32] = addr_q[e];
  end

  always_comb begin
    rd_val = 32'h0;
    rd_err = 1'b0;
    if (is_cfg) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (e / 4 == int'(csr_addr[1:0])) rd_val[8*(e%4) +: 8] = cfg_q[e];
      end
    end else if (is_addr) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (e == int'(csr_addr[3:0])) rd_val = addr_q[e];
      end
    end else begin
      rd_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        cfg_q[e]  <= 8'h00;
        addr_q[e] <= 32'h0;
      end
    end else begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (cfg_we[e])  cfg_q[e]  <= csr_wdata[8*(e%4) +: 8] & 8'h9F;
        if (addr_we[e]) addr_q[e] <= csr_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rsp_valid <= 1'b0;
      csr_rdata     <= 32'h0;
      csr_rsp_err   <= 1'b0;
    end else if (accept) begin
      csr_rsp_valid <= 1'b1;
      csr_rdata     <= rd_val;
      csr_rsp_err   <= rd_err;
    end else if (csr_rsp_ready) begin
      csr_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pmp_csr_regs.sv
// Directed and randomized bench for pmp_csr_regs against an array-based
// model of the PMP CSR rules.
module tb_pmp_csr_regs;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          csr_req_valid = 1'b0;
  logic          csr_req_ready;
  logic          csr_we = 1'b0;
  logic [11:0]   csr_addr = 12'h0;
  logic [31:0]   csr_wdata = 32'h0;
  logic          csr_rsp_valid;
  logic          csr_rsp_ready = 1'b1;
  logic [31:0]   csr_rdata;
  logic          csr_rsp_err;
  logic [8*N-1:0]  pmpcfg_o;
  logic [32*N-1:0] pmpaddr_o;

  pmp_csr_regs #(.NUM_ENTRIES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rsp_valid(csr_rsp_valid), .csr_rsp_ready(csr_rsp_ready),
    .csr_rdata(csr_rdata), .csr_rsp_err(csr_rsp_err),
    .pmpcfg_o(pmpcfg_o), .pmpaddr_o(pmpaddr_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  m_cfg  [N];
  logic [31:0] m_addr [N];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin
      m_cfg[i] = 8'h00;
      m_addr[i] = 32'h0;
    end
  endtask

  function automatic logic [8*N-1:0] flat_cfg();
    logic [8*N-1:0] v;
    for (int i = 0; i < N; i++) v[8*i +: 8] = m_cfg[i];
    return v;
  endfunction

  function automatic logic [32*N-1:0] flat_addr();
    logic [32*N-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = m_addr[i];
    return v;
  endfunction

  // Reference model of one CSR access: returns the pre-write value and applies the write.
  task automatic m_access(input logic we, input logic [11:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err);
    int k;
    int i;
    logic [7:0] b;
    logic locked;
    rd = 32'h0;
    err = 1'b0;
    if (a >= 12'h3A0 && a <= 12'h3A3) begin
      k = int'(a - 12'h3A0);
      for (int j = 0; j < 4; j++) rd[8*j +: 8] = m_cfg[4*k + j];
      if (we) begin
        for (int j = 0; j < 4; j++) begin
          b = wd[8*j +: 8];
          if (!m_cfg[4*k + j][7] && !(b[0] == 1'b0 && b[1] == 1'b1))
            m_cfg[4*k + j] = b & 8'h9F;
        end
      end
    end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
      i = int'(a - 12'h3B0);
      rd = m_addr[i];
      locked = m_cfg[i][7];
      if (i < N - 1 && m_cfg[i+1][7] && m_cfg[i+1][4:3] == 2'b01) locked = 1'b1;
      if (we && !locked) m_addr[i] = wd;
    end else begin
      err = 1'b1;
    end
  endtask

  // Issue one request with rsp_ready high; called at posedge+1.
  task automatic do_req(input logic we, input logic [11:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    logic exp_err;
    csr_req_valid = 1'b1;
    csr_we = we;
    csr_addr = a;
    csr_wdata = wd;
    #1;
    chk("req_ready", csr_req_ready, 1'b1);
    m_access(we, a, wd, exp_rd, exp_err);
    @(posedge clk);
    #1;
    csr_req_valid = 1'b0;
    chk("rsp_valid", csr_rsp_valid, 1'b1);
    chk($sformatf("rdata@%0h", a), csr_rdata, exp_rd);
    chk($sformatf("err@%0h", a), csr_rsp_err, exp_err);
    chk("pmpcfg_o", pmpcfg_o, flat_cfg());
    chk("pmpaddr_o", pmpaddr_o, flat_addr());
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held_rd;
    logic [31:0] exp_rd;
    logic exp_err;
    logic [11:0] a;
    logic [31:0] wd;
    int sel;

    // T1 reset
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_pmpcfg", pmpcfg_o, '0);
    chk("rst_pmpaddr", pmpaddr_o, '0);
    chk("rst_rsp_valid", csr_rsp_valid, 1'b0);
    chk("rst_req_ready", csr_req_ready, 1'b1);
    chk("rst_rdata", csr_rdata, 32'h0);
    idle();

    // T2 address write/read
    do_req(1'b1, 12'h3B0, 32'h2000_0000);
    chk("t2_pmpaddr0", pmpaddr_o[31:0], 32'h2000_0000);
    do_req(1'b0, 12'h3B0, 32'h0);
    chk("t2_read", csr_rdata, 32'h2000_0000);

    // T3 WARL: reserved bits cleared, W-only byte rejected
    do_req(1'b1, 12'h3A0, 32'h0000_0263);
    chk("t3_byte0", pmpcfg_o[7:0], 8'h03);
    chk("t3_byte1", pmpcfg_o[15:8], 8'h00);
    do_req(1'b0, 12'h3A0, 32'h0);
    chk("t3_read", csr_rdata, 32'h0000_0003);

    // T4 lock with TOR on entry 1
    do_req(1'b1, 12'h3A0, 32'h0000_8800);
    do_req(1'b1, 12'h3B1, 32'h1234_5678);
    do_req(1'b1, 12'h3B0, 32'h0BAD_0000);
    chk("t4_addr0_kept", pmpaddr_o[31:0], 32'h2000_0000);
    chk("t4_addr1_kept", pmpaddr_o[63:32], 32'h0);
    do_req(1'b1, 12'h3A0, 32'h0000_8807);
    chk("t4_byte0", pmpcfg_o[7:0], 8'h07);
    chk("t4_byte1", pmpcfg_o[15:8], 8'h88);
    do_req(1'b1, 12'h3B2, 32'h0000_0040);

    // T5 backpressure
    idle();
    csr_rsp_ready = 1'b0;
    do_req(1'b0, 12'h3B2, 32'h0);
    held_rd = 32'h0000_0040;
    csr_req_valid = 1'b1;
    csr_we = 1'b1;
    csr_addr = 12'h3B2;
    csr_wdata = 32'hCAFE_0000;
    for (int c = 0; c < 3; c++) begin
      idle();
      chk("t5_valid_held", csr_rsp_valid, 1'b1);
      chk("t5_rdata_held", csr_rdata, held_rd);
      chk("t5_req_ready", csr_req_ready, 1'b0);
      chk("t5_no_write", pmpaddr_o[95:64], 32'h0000_0040);
    end
    csr_rsp_ready = 1'b1;
    #1;
    chk("t5_ready_again", csr_req_ready, 1'b1);
    m_access(1'b1, 12'h3B2, 32'hCAFE_0000, exp_rd, exp_err);
    idle();
    csr_req_valid = 1'b0;
    chk("t5_rsp_valid", csr_rsp_valid, 1'b1);
    chk("t5_rdata", csr_rdata, exp_rd);
    chk("t5_addr2", pmpaddr_o[95:64], 32'hCAFE_0000);

    // T6 bad address, then reset during a stalled response
    do_req(1'b1, 12'h3C0, 32'hFFFF_FFFF);
    chk("t6_err", csr_rsp_err, 1'b1);
    chk("t6_rdata", csr_rdata, 32'h0);
    idle();
    csr_rsp_ready = 1'b0;
    do_req(1'b0, 12'h3A0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rsp_valid", csr_rsp_valid, 1'b0);
    chk("t6_rst_pmpcfg", pmpcfg_o, '0);
    m_clear();
    csr_rsp_ready = 1'b1;
    idle();
    rst_n = 1'b1;
    idle();

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      if (n == 150) begin
        rst_n = 1'b0;
        #1;
        chk("rand_rst_valid", csr_rsp_valid, 1'b0);
        m_clear();
        idle();
        rst_n = 1'b1;
        idle();
      end
      sel = $urandom_range(0, 9);
      if (sel < 4)       a = 12'h3A0 + 12'($urandom_range(0, 3));
      else if (sel < 8)  a = 12'h3B0 + 12'($urandom_range(0, 15));
      else if (sel == 8) a = 12'h3A4 + 12'($urandom_range(0, 11));
      else               a = 12'($urandom_range(0, 4095));
      wd = $urandom;
      if ($urandom_range(0, 15) != 0) wd = wd & 32'h7F7F_7F7F;
      do_req(1'($urandom_range(0, 1)), a, wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL timeout observed=running expected=finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
